// File: rtl/udp_tx_arb_pkg.sv
// Shared types and constants for the two-channel UDP TX arbiter.
package udp_tx_arb_pkg;

   localparam int DATA_W = 64;
   localparam int KEEP_W = 8;
   localparam int USER_W = 32;
   localparam int LEN_W  = 16;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_XFER = 2'd2,
      ST_GAP  = 2'd3
   } arb_state_t;

   // Downstream user word: channel id in bit 16, payload length below it.
   function automatic logic [USER_W-1:0] make_user(input logic ch, input logic [LEN_W-1:0] len);
      return {15'd0, ch, len};
   endfunction

endpackage

// File: rtl/udp_tx_arb2_rr.sv
// Combinational two-way round-robin picker; the pointer lives in the parent.
module udp_rr_arb2
   import udp_tx_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_served_i,
   output logic       winner_o,
   output logic       any_req_o
);

   // Single requester wins; on contention the channel not served last wins.
   always_comb begin
      any_req_o = |req_i;
      if (req_i == 2'b11) begin
         winner_o = ~last_served_i;
      end else if (req_i[1]) begin
         winner_o = CH1;
      end else begin
         winner_o = CH0;
      end
   end

endmodule

// File: rtl/udp_tx_arb2.sv
// Packet-granular round-robin arbiter sharing one UDP TX stream between two sources.
module udp_tx_arb2
   import udp_tx_arb_pkg::*;
#(
   parameter logic [15:0] P_START_TIMEOUT = 16'd256,
   parameter logic [7:0]  P_IFG           = 8'd2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_udp_tx_ready,
   input  logic              i_ch0_req,
   input  logic              i_ch1_req,
   output logic              o_ch0_grant,
   output logic              o_ch1_grant,
   input  logic [DATA_W-1:0] s_axis_ch0_data,
   input  logic [USER_W-1:0] s_axis_ch0_user,
   input  logic [KEEP_W-1:0] s_axis_ch0_keep,
   input  logic              s_axis_ch0_last,
   input  logic              s_axis_ch0_valid,
   input  logic [DATA_W-1:0] s_axis_ch1_data,
   input  logic [USER_W-1:0] s_axis_ch1_user,
   input  logic [KEEP_W-1:0] s_axis_ch1_keep,
   input  logic              s_axis_ch1_last,
   input  logic              s_axis_ch1_valid,
   output logic [DATA_W-1:0] m_axis_udp_data,
   output logic [USER_W-1:0] m_axis_udp_user,
   output logic [KEEP_W-1:0] m_axis_udp_keep,
   output logic              m_axis_udp_last,
   output logic              m_axis_udp_valid,
   output logic              o_timeout,
   output logic [15:0]       o_ch0_pkt_cnt,
   output logic [15:0]       o_ch1_pkt_cnt
);

   arb_state_t        state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic              gch_q, gch_d;
   logic              last_served_q, last_served_d;
   logic [15:0]       timer_q, timer_d;
   logic [7:0]        gap_q, gap_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [USER_W-1:0] user_q, user_d;
   logic [KEEP_W-1:0] keep_q, keep_d;
   logic              last_q, last_d;
   logic              valid_q, valid_d;
   logic              timeout_q, timeout_d;
   logic [15:0]       cnt0_q, cnt0_d;
   logic [15:0]       cnt1_q, cnt1_d;

   logic              rr_winner_s;
   logic              rr_any_s;
   logic              sel_req_s;
   logic              sel_valid_s;
   logic              sel_last_s;
   logic [DATA_W-1:0] sel_data_s;
   logic [KEEP_W-1:0] sel_keep_s;
   logic [LEN_W-1:0]  sel_len_s;
   logic              unused_user_s;

   // Upper user bits carry nothing for this block.
   assign unused_user_s = ^{s_axis_ch0_user[31:16], s_axis_ch1_user[31:16]};

   udp_rr_arb2 u_rr (
      .req_i         ({i_ch1_req, i_ch0_req}),
      .last_served_i (last_served_q),
      .winner_o      (rr_winner_s),
      .any_req_o     (rr_any_s)
   );

   // Route the granted channel's stream and request to the FSM.
   always_comb begin
      if (gch_q == CH1) begin
         sel_req_s   = i_ch1_req;
         sel_valid_s = s_axis_ch1_valid;
         sel_last_s  = s_axis_ch1_last;
         sel_data_s  = s_axis_ch1_data;
         sel_keep_s  = s_axis_ch1_keep;
         sel_len_s   = s_axis_ch1_user[15:0];
      end else begin
         sel_req_s   = i_ch0_req;
         sel_valid_s = s_axis_ch0_valid;
         sel_last_s  = s_axis_ch0_last;
         sel_data_s  = s_axis_ch0_data;
         sel_keep_s  = s_axis_ch0_keep;
         sel_len_s   = s_axis_ch0_user[15:0];
      end
   end

   // Next-state logic: arbitration, start timeout, beat forwarding and inter-packet gap.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      gch_d         = gch_q;
      last_served_d = last_served_q;
      timer_d       = timer_q;
      gap_d         = gap_q;
      data_d        = data_q;
      user_d        = user_q;
      keep_d        = keep_q;
      last_d        = 1'b0;
      valid_d       = 1'b0;
      timeout_d     = 1'b0;
      cnt0_d        = cnt0_q;
      cnt1_d        = cnt1_q;

      case (state_q)
         ST_IDLE: begin
            if (i_udp_tx_ready && rr_any_s) begin
               gch_d   = rr_winner_s;
               grant_d = (rr_winner_s == CH1) ? 2'b10 : 2'b01;
               timer_d = 16'd0;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT, ST_XFER: begin
            if (sel_valid_s) begin
               valid_d = 1'b1;
               data_d  = sel_data_s;
               keep_d  = sel_keep_s;
               last_d  = sel_last_s;
               if (state_q == ST_WAIT) begin
                  user_d = make_user(gch_q, sel_len_s);
               end else begin
                  user_d = user_q;
               end
               if (sel_last_s) begin
                  grant_d       = 2'b00;
                  last_served_d = gch_q;
                  gap_d         = 8'd0;
                  state_d       = ST_GAP;
                  if (gch_q == CH1) begin
                     cnt1_d = cnt1_q + 16'd1;
                  end else begin
                     cnt0_d = cnt0_q + 16'd1;
                  end
               end else begin
                  state_d = ST_XFER;
               end
            end else if (state_q == ST_XFER) begin
               state_d = ST_XFER;
            end else if (!sel_req_s) begin
               // Request withdrawn before the first beat: pointer stays put.
               grant_d = 2'b00;
               state_d = ST_IDLE;
            end else if (timer_q == (P_START_TIMEOUT - 16'd1)) begin
               // Stalled start: revoke and treat the channel as served.
               grant_d       = 2'b00;
               timeout_d     = 1'b1;
               last_served_d = gch_q;
               state_d       = ST_IDLE;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         ST_GAP: begin
            if (gap_q == (P_IFG - 8'd1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         grant_q       <= 2'b00;
         gch_q         <= CH0;
         last_served_q <= CH1;
         timer_q       <= 16'd0;
         gap_q         <= 8'd0;
         data_q        <= '0;
         user_q        <= '0;
         keep_q        <= '0;
         last_q        <= 1'b0;
         valid_q       <= 1'b0;
         timeout_q     <= 1'b0;
         cnt0_q        <= 16'd0;
         cnt1_q        <= 16'd0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         gch_q         <= gch_d;
         last_served_q <= last_served_d;
         timer_q       <= timer_d;
         gap_q         <= gap_d;
         data_q        <= data_d;
         user_q        <= user_d;
         keep_q        <= keep_d;
         last_q        <= last_d;
         valid_q       <= valid_d;
         timeout_q     <= timeout_d;
         cnt0_q        <= cnt0_d;
         cnt1_q        <= cnt1_d;
      end
   end

   assign o_ch0_grant      = grant_q[0];
   assign o_ch1_grant      = grant_q[1];
   assign m_axis_udp_data  = data_q;
   assign m_axis_udp_user  = user_q;
   assign m_axis_udp_keep  = keep_q;
   assign m_axis_udp_last  = last_q;
   assign m_axis_udp_valid = valid_q;
   assign o_timeout        = timeout_q;
   assign o_ch0_pkt_cnt    = cnt0_q;
   assign o_ch1_pkt_cnt    = cnt1_q;

endmodule

// File: tb/tb_udp_tx_arb2.sv
// Directed self-checking bench for udp_tx_arb2 (P_START_TIMEOUT=8, P_IFG=2).
module tb_udp_tx_arb2;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_udp_tx_ready;
   logic        i_ch0_req, i_ch1_req;
   logic        o_ch0_grant, o_ch1_grant;
   logic [63:0] ch0_data, ch1_data;
   logic [31:0] ch0_user, ch1_user;
   logic [7:0]  ch0_keep, ch1_keep;
   logic        ch0_last, ch1_last, ch0_valid, ch1_valid;
   logic [63:0] m_data;
   logic [31:0] m_user;
   logic [7:0]  m_keep;
   logic        m_last, m_valid, o_timeout;
   logic [15:0] cnt0, cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   udp_tx_arb2 #(.P_START_TIMEOUT(16'd8), .P_IFG(8'd2)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_udp_tx_ready(i_udp_tx_ready),
      .i_ch0_req(i_ch0_req), .i_ch1_req(i_ch1_req),
      .o_ch0_grant(o_ch0_grant), .o_ch1_grant(o_ch1_grant),
      .s_axis_ch0_data(ch0_data), .s_axis_ch0_user(ch0_user), .s_axis_ch0_keep(ch0_keep),
      .s_axis_ch0_last(ch0_last), .s_axis_ch0_valid(ch0_valid),
      .s_axis_ch1_data(ch1_data), .s_axis_ch1_user(ch1_user), .s_axis_ch1_keep(ch1_keep),
      .s_axis_ch1_last(ch1_last), .s_axis_ch1_valid(ch1_valid),
      .m_axis_udp_data(m_data), .m_axis_udp_user(m_user), .m_axis_udp_keep(m_keep),
      .m_axis_udp_last(m_last), .m_axis_udp_valid(m_valid),
      .o_timeout(o_timeout), .o_ch0_pkt_cnt(cnt0), .o_ch1_pkt_cnt(cnt1)
   );

   always #5 i_clk = ~i_clk;

   // Grants must never overlap.
   always @(negedge i_clk) begin
      n_tests++;
      assert (!(o_ch0_grant && o_ch1_grant)) else begin
         n_fail++;
         $error("FAIL grant_excl: observed both grants high, expected at most one");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ch, input logic v, input logic [63:0] d,
                        input logic [15:0] len, input logic [7:0] k, input logic l);
      if (ch == 1'b0) begin
         ch0_valid = v; ch0_data = d; ch0_user = {16'hABCD, len}; ch0_keep = k; ch0_last = l;
      end else begin
         ch1_valid = v; ch1_data = d; ch1_user = {16'h5A5A, len}; ch1_keep = k; ch1_last = l;
      end
   endtask

   task automatic wait_grant(input logic ch, input int exp_wait, input string tag);
      int waited = 0;
      while (!(o_ch0_grant || o_ch1_grant) && waited < 50) begin
         step();
         waited++;
      end
      chk({tag, "_wait"}, waited, exp_wait);
      chk({tag, "_gch"}, ch ? o_ch1_grant : o_ch0_grant, 1);
   endtask

   task automatic serve(input logic ch, input int nbeats, input logic [63:0] base,
                        input logic [15:0] len, input int exp_wait, input string tag);
      wait_grant(ch, exp_wait, tag);
      for (int i = 0; i < nbeats; i++) begin
         drive(ch, 1'b1, base + 64'(i), len, (i == nbeats-1) ? 8'h0F : 8'hFF, i == nbeats-1);
         step();
         chk({tag, "_valid"}, m_valid, 1);
         chk({tag, "_data"},  m_data, base + 64'(i));
         chk({tag, "_user"},  m_user, {15'd0, ch, len});
         chk({tag, "_keep"},  m_keep, (i == nbeats-1) ? 8'h0F : 8'hFF);
         chk({tag, "_last"},  m_last, (i == nbeats-1) ? 1 : 0);
         chk({tag, "_grant"}, ch ? o_ch1_grant : o_ch0_grant, (i == nbeats-1) ? 0 : 1);
      end
      drive(ch, 1'b0, 64'd0, 16'd0, 8'd0, 1'b0);
   endtask

   initial begin
      i_rst = 1'b1; i_udp_tx_ready = 1'b1; i_ch0_req = 1'b0; i_ch1_req = 1'b0;
      drive(1'b0, 1'b0, 64'd0, 16'd0, 8'd0, 1'b0);
      drive(1'b1, 1'b0, 64'd0, 16'd0, 8'd0, 1'b0);
      step(); step();
      chk("rst_g0", o_ch0_grant, 0);
      chk("rst_g1", o_ch1_grant, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_user", m_user, 0);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_timeout", o_timeout, 0);
      i_rst = 1'b0;

      // 1: single ch0 packet, 3 beats, len 20
      i_ch0_req = 1'b1;
      serve(1'b0, 3, 64'h0000_0000_1000_0000, 16'd20, 1, "t1");
      i_ch0_req = 1'b0;
      chk("t1_cnt0", cnt0, 1);
      chk("t1_user", m_user, 32'h0000_0014);
      step();
      chk("t1_vdrop", m_valid, 0);
      chk("t1_ldrop", m_last, 0);

      // 2: continuous contention from reset, alternating service
      i_rst = 1'b1;
      step();
      chk("t2_rstcnt", cnt0, 0);
      i_rst = 1'b0; i_ch0_req = 1'b1; i_ch1_req = 1'b1;
      serve(1'b0, 2, 64'h0000_0000_2000_0000, 16'd16, 1, "t2a");
      serve(1'b1, 2, 64'h0000_0000_2100_0000, 16'd12, 3, "t2b");
      serve(1'b0, 2, 64'h0000_0000_2200_0000, 16'd10, 3, "t2c");
      serve(1'b1, 2, 64'h0000_0000_2300_0000, 16'd9,  3, "t2d");
      i_ch0_req = 1'b0; i_ch1_req = 1'b0;
      chk("t2_cnt0", cnt0, 2);
      chk("t2_cnt1", cnt1, 2);

      // 3: ch1 packet with a 4-cycle valid hole while ch0 toggles valid
      i_ch1_req = 1'b1;
      wait_grant(1'b1, 3, "t3");
      drive(1'b1, 1'b1, 64'h1111_0000, 16'd16, 8'hFF, 1'b0);
      step();
      chk("t3_b0", m_data, 64'h1111_0000);
      chk("t3_u0", m_user, 32'h0001_0010);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 64'h0, 16'd16, 8'hFF, 1'b0);
         drive(1'b0, i[0], 64'hBAD0_BAD0, 16'd99, 8'hFF, 1'b1);
         step();
         chk("t3_hole", m_valid, 0);
         chk("t3_hold", o_ch1_grant, 1);
      end
      drive(1'b0, 1'b0, 64'd0, 16'd0, 8'd0, 1'b0);
      drive(1'b1, 1'b1, 64'h1111_0001, 16'd16, 8'h0F, 1'b1);
      step();
      chk("t3_b1", m_data, 64'h1111_0001);
      chk("t3_last", m_last, 1);
      chk("t3_user", m_user, 32'h0001_0010);
      chk("t3_gdrop", o_ch1_grant, 0);
      chk("t3_cnt1", cnt1, 3);
      chk("t3_cnt0", cnt0, 2);
      drive(1'b1, 1'b0, 64'd0, 16'd0, 8'd0, 1'b0);
      i_ch1_req = 1'b0;

      // 4: ch0 never starts; revoked after 8 grant cycles, ch1 follows
      i_ch0_req = 1'b1; i_ch1_req = 1'b1;
      wait_grant(1'b0, 3, "t4");
      for (int i = 1; i < 8; i++) begin
         step();
         chk("t4_held", o_ch0_grant, 1);
         chk("t4_noto", o_timeout, 0);
      end
      step();
      chk("t4_revoke", o_ch0_grant, 0);
      chk("t4_pulse", o_timeout, 1);
      step();
      chk("t4_pulse_end", o_timeout, 0);
      chk("t4_g1", o_ch1_grant, 1);
      chk("t4_cnt0", cnt0, 2);
      i_ch0_req = 1'b0;
      serve(1'b1, 1, 64'h4444_0000, 16'd8, 0, "t4s");
      i_ch1_req = 1'b0;
      chk("t4_cnt1", cnt1, 4);

      // 5: ready gating in IDLE only
      i_udp_tx_ready = 1'b0; i_ch0_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t5_nogrant", o_ch0_grant, 0);
      end
      i_udp_tx_ready = 1'b1;
      step();
      chk("t5_grant", o_ch0_grant, 1);
      i_udp_tx_ready = 1'b0;
      serve(1'b0, 3, 64'h5555_0000, 16'd24, 0, "t5p");
      i_udp_tx_ready = 1'b1;
      chk("t5_cnt0", cnt0, 3);

      // 6: reset mid-packet truncates output, ch0 wins first contention after
      wait_grant(1'b0, 3, "t6");
      drive(1'b0, 1'b1, 64'h6666_0000, 16'd32, 8'hFF, 1'b0);
      step();
      chk("t6_b0", m_valid, 1);
      drive(1'b0, 1'b1, 64'h6666_0001, 16'd32, 8'hFF, 1'b0);
      i_rst = 1'b1;
      step();
      chk("t6_valid", m_valid, 0);
      chk("t6_last", m_last, 0);
      chk("t6_data", m_data, 0);
      chk("t6_user", m_user, 0);
      chk("t6_keep", m_keep, 0);
      chk("t6_g0", o_ch0_grant, 0);
      chk("t6_cnt0", cnt0, 0);
      chk("t6_cnt1", cnt1, 0);
      i_rst = 1'b0; i_ch1_req = 1'b1;
      drive(1'b0, 1'b1, 64'h6666_0002, 16'd32, 8'h0F, 1'b1);
      step();
      chk("t6_nolast", m_last, 0);
      chk("t6_novalid", m_valid, 0);
      chk("t6_first_g0", o_ch0_grant, 1);
      chk("t6_first_g1", o_ch1_grant, 0);
      drive(1'b0, 1'b0, 64'd0, 16'd0, 8'd0, 1'b0);
      i_ch0_req = 1'b0; i_ch1_req = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
